ic_bram_cpu_bus_initiator: RTL and testbench
============================================

Name: ic_bram_cpu_bus_initiator

Overview:
- Reverse of the CPU-bus-to-BRAM bridge: presents a BRAM-style responder port to a simple local master (DMA, debug unit, boot loader) and drives the CPU request/response bus protocol as initiator.
- Converts BRAM cen/stall/rdata semantics into mem_req/gnt/recv/ack transactions.
- Sits between a non-CPU master and the interconnect's CPU-bus slave ports.
- Exactly one transaction is outstanding at any time.

Parameters:
- AW, 32, address width on both sides.
- DW, 32, data width on both sides; strobe width is DW/8.

Ports:
- g_clk  in  1  clock.
- g_resetn  in  1  reset; asynchronous assert, active-low.
- bram_cen  in  1  local request valid; held with stable fields while bram_stall=1.
- bram_addr  in  AW  local address.
- bram_wdata  in  DW  local write data.
- bram_wstrb  in  DW/8  write strobe; all-zero means read.
- bram_stall  out  1  request not accepted this cycle.
- bram_rdata  out  DW  read data; valid in the cycle after acceptance.
- bram_error  out  1  bus error flag for the last accepted request; valid in the cycle after acceptance.
- mem_req  out  1  bus request.
- mem_gnt  in  1  bus request accepted.
- mem_wen  out  1  write enable; equals |wstrb of the captured request.
- mem_strb  out  DW/8  captured strobe.
- mem_wdata  out  DW  captured write data.
- mem_addr  out  AW  captured address.
- mem_recv  in  1  bus response valid.
- mem_ack  out  1  response accepted.
- mem_error  in  1  bus response error.
- mem_rdata  in  DW  bus response data.

Behaviour:
- Reset (async, g_resetn=0):
  - state=IDLE; mem_req=0, mem_ack=0.
  - Captured addr/wdata/strb and bram_rdata/bram_error registers all zero.
  - Release is synchronous to g_clk.
- FSM states: IDLE, REQ, RSP, DONE.
- IDLE:
  - bram_stall = bram_cen.
  - On bram_cen=1: capture addr/wdata/wstrb, go to REQ.
- REQ:
  - mem_req=1 with captured fields; bram_stall=1.
  - mem_req stays high until mem_gnt=1; captured fields do not change while it is high.
  - On mem_gnt=1, go to RSP. mem_req is low from the next cycle.
- RSP:
  - mem_ack = mem_recv (combinational; responses are accepted in the cycle they arrive); bram_stall=1.
  - On mem_recv=1:
    - bram_error <= mem_error.
    - If read (captured wstrb==0), bram_rdata <= mem_rdata.
    - Go to DONE.
- Gnt and recv in the same cycle while in REQ: not allowed by the bus (recv is at least one cycle after gnt). A recv while in REQ is ignored and mem_ack stays 0.
- DONE:
  - bram_stall=0, so the held bram_cen is accepted this cycle.
  - bram_rdata/bram_error are stable from the next cycle until the next completion.
  - Next state is IDLE. A new request is therefore seen no earlier than the following cycle.
- Minimum latency: cen rise to acceptance is 3 cycles with gnt and recv each immediate; data is available one cycle after acceptance.
- Writes: bram_rdata holds its previous value; bram_error is updated.
- bram_cen dropped while in REQ or RSP (master violation):
  - The bus transaction still completes and is acked.
  - Its result is written but no acceptance occurs.
  - DONE falls through to IDLE.
- Reset during REQ or RSP: the transaction is abandoned and mem_req drops immediately (async). The system resets bus responders together with this block.
- No combinational path from mem_recv to any bram_* output except through registers. mem_recv to mem_ack is the only combinational bus path.

Decomposition:
- Shared interconnect package:
  - FSM state encoding (2-bit: IDLE=0, REQ=1, RSP=2, DONE=3).
  - Default AW/DW constants.
  - A "read = strobe zero" helper constant.
- No sub-module needed. The capture register bank stays inline; the block is one FSM plus datapath registers.

Test Plan:
- Read with zero-wait bus: cen=1, addr=0x0000_1000, wstrb=0; gnt and recv each asserted the first cycle they are possible, rdata=0xDEAD_BEEF -> mem_req for exactly 1 cycle; stall high 3 cycles; bram_rdata=0xDEAD_BEEF and bram_error=0 one cycle after acceptance.
- Write with delayed gnt: addr=0x20, wdata=0x1234_5678, wstrb=4'b0011; gnt held off 4 cycles -> mem_req high 5 cycles with stable fields; mem_wen=1, mem_strb=0011; bram_rdata unchanged.
- Error response: read with mem_error=1 on recv -> bram_error=1 after acceptance; the next clean read clears it to 0.
- Back-to-back reads at 0x0, 0x4 with the master re-asserting cen immediately -> two distinct bus transactions, no overlap of mem_req with a pending response, correct data per address.
- Async reset asserted while in RSP -> mem_req=0, mem_ack=0, bram_stall follows cen in IDLE, registers zero, before the next clock edge.
- cen dropped while in RSP -> mem_ack still pulses on recv; FSM returns to IDLE; no spurious acceptance.

Source files
------------

// File: rtl/ic_bram_cpu_bus_initiator_pkg.sv
// Shared interconnect definitions for the BRAM-port-to-CPU-bus initiator.
package ic_bram_cpu_bus_initiator_pkg;

  localparam int unsigned IC_AW_DEFAULT = 32;
  localparam int unsigned IC_DW_DEFAULT = 32;

  // A request whose strobe reduces to this value is a read.
  localparam logic IC_WEN_READ = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RSP  = 2'd2,
    ST_DONE = 2'd3
  } ic_init_state_t;

endpackage

// File: rtl/ic_bram_cpu_bus_initiator.sv
// BRAM-style responder port for a local master, driving one outstanding
// CPU-bus transaction at a time (req/gnt then recv/ack).
module ic_bram_cpu_bus_initiator
  import ic_bram_cpu_bus_initiator_pkg::*;
#(
  parameter int unsigned AW = IC_AW_DEFAULT,
  parameter int unsigned DW = IC_DW_DEFAULT
) (
  input  logic            g_clk,
  input  logic            g_resetn,
  input  logic            bram_cen,
  input  logic [AW-1:0]   bram_addr,
  input  logic [DW-1:0]   bram_wdata,
  input  logic [DW/8-1:0] bram_wstrb,
  output logic            bram_stall,
  output logic [DW-1:0]   bram_rdata,
  output logic            bram_error,
  output logic            mem_req,
  input  logic            mem_gnt,
  output logic            mem_wen,
  output logic [DW/8-1:0] mem_strb,
  output logic [DW-1:0]   mem_wdata,
  output logic [AW-1:0]   mem_addr,
  input  logic            mem_recv,
  output logic            mem_ack,
  input  logic            mem_error,
  input  logic [DW-1:0]   mem_rdata
);

  ic_init_state_t r_state;
  ic_init_state_t w_state_nxt;

  logic [AW-1:0]   r_addr;
  logic [DW-1:0]   r_wdata;
  logic [DW/8-1:0] r_strb;
  logic [DW-1:0]   r_rdata;
  logic            r_error;

  logic            w_capture;
  logic            w_complete;
  logic            w_is_read;

  assign w_capture  = (r_state == ST_IDLE) && bram_cen;
  assign w_complete = (r_state == ST_RSP) && mem_recv;
  assign w_is_read  = ((|r_strb) == IC_WEN_READ);

  // State register; reset abandons any in-flight bus transaction.
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; DONE always returns to IDLE so the held cen is
  // re-sampled as a fresh request no earlier than the following cycle.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: if (bram_cen) w_state_nxt = ST_REQ;
      ST_REQ:  if (mem_gnt)  w_state_nxt = ST_RSP;
      ST_RSP:  if (mem_recv) w_state_nxt = ST_DONE;
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Outputs decoded from state; mem_recv reaches only mem_ack combinationally.
  always_comb begin
    mem_req    = 1'b0;
    mem_ack    = 1'b0;
    bram_stall = 1'b1;
    unique case (r_state)
      ST_IDLE: bram_stall = bram_cen;
      ST_REQ:  mem_req    = 1'b1;
      ST_RSP:  mem_ack    = mem_recv;
      ST_DONE: bram_stall = 1'b0;
      default: bram_stall = bram_cen;
    endcase
  end

  // Capture the local request; fields stay frozen until the next IDLE.
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_strb  <= '0;
    end else if (w_capture) begin
      r_addr  <= bram_addr;
      r_wdata <= bram_wdata;
      r_strb  <= bram_wstrb;
    end
  end

  // Register the bus response; writes leave read data untouched.
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      r_rdata <= '0;
      r_error <= 1'b0;
    end else if (w_complete) begin
      r_error <= mem_error;
      if (w_is_read) begin
        r_rdata <= mem_rdata;
      end
    end
  end

  assign mem_addr   = r_addr;
  assign mem_wdata  = r_wdata;
  assign mem_strb   = r_strb;
  assign mem_wen    = |r_strb;
  assign bram_rdata = r_rdata;
  assign bram_error = r_error;

endmodule

// File: tb/tb_ic_bram_cpu_bus_initiator.sv
// Directed plus randomized bench for the BRAM-to-CPU-bus initiator.
module tb_ic_bram_cpu_bus_initiator;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic            g_clk = 1'b0;
  logic            g_resetn = 1'b0;
  logic            bram_cen = 1'b0;
  logic [AW-1:0]   bram_addr = '0;
  logic [DW-1:0]   bram_wdata = '0;
  logic [DW/8-1:0] bram_wstrb = '0;
  logic            bram_stall;
  logic [DW-1:0]   bram_rdata;
  logic            bram_error;
  logic            mem_req;
  logic            mem_gnt = 1'b0;
  logic            mem_wen;
  logic [DW/8-1:0] mem_strb;
  logic [DW-1:0]   mem_wdata;
  logic [AW-1:0]   mem_addr;
  logic            mem_recv = 1'b0;
  logic            mem_ack;
  logic            mem_error = 1'b0;
  logic [DW-1:0]   mem_rdata = '0;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state: the result of the last completed transaction.
  logic [DW-1:0] exp_rdata = '0;
  logic          exp_err   = 1'b0;

  // Word-addressed backing store the bus responder serves reads from.
  logic [DW-1:0] mem_model [0:255];

  ic_bram_cpu_bus_initiator #(.AW(AW), .DW(DW)) dut (
    .g_clk      (g_clk),
    .g_resetn   (g_resetn),
    .bram_cen   (bram_cen),
    .bram_addr  (bram_addr),
    .bram_wdata (bram_wdata),
    .bram_wstrb (bram_wstrb),
    .bram_stall (bram_stall),
    .bram_rdata (bram_rdata),
    .bram_error (bram_error),
    .mem_req    (mem_req),
    .mem_gnt    (mem_gnt),
    .mem_wen    (mem_wen),
    .mem_strb   (mem_strb),
    .mem_wdata  (mem_wdata),
    .mem_addr   (mem_addr),
    .mem_recv   (mem_recv),
    .mem_ack    (mem_ack),
    .mem_error  (mem_error),
    .mem_rdata  (mem_rdata)
  );

  always #5 g_clk = ~g_clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge g_clk);
    #1;
  endtask

  // One bus transaction seen from both sides. Called one step after an edge
  // with the DUT in IDLE. gdly/rdly are idle cycles before gnt/recv.
  task automatic txn(input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                     input logic [DW/8-1:0] strb, input int gdly, input int rdly,
                     input logic [DW-1:0] rdata, input logic err,
                     input bit drop_cen, input bit noise_recv, input bit b2b);
    // Previous result is still held one cycle after acceptance.
    chk("hold_rdata", bram_rdata, exp_rdata);
    chk("hold_error", bram_error, exp_err);
    bram_cen = 1'b1; bram_addr = addr; bram_wdata = wdata; bram_wstrb = strb;
    #1;
    chk("idle_stall", bram_stall, 1);
    chk("idle_req", mem_req, 0);
    tick();
    for (int i = 0; i < gdly; i++) begin
      mem_recv = noise_recv;
      mem_rdata = 32'hBAD0_0000 | i;
      mem_error = noise_recv;
      bram_addr = ~addr; bram_wdata = ~wdata;  // captured fields must not follow
      #1;
      chk("req_wait_req", mem_req, 1);
      chk("req_wait_addr", mem_addr, addr);
      chk("req_wait_wdata", mem_wdata, wdata);
      chk("req_wait_strb", mem_strb, strb);
      chk("req_wait_stall", bram_stall, 1);
      chk("req_recv_ignored", mem_ack, 0);
      tick();
    end
    mem_recv = 1'b0; mem_error = 1'b0;
    bram_addr = addr; bram_wdata = wdata;
    mem_gnt = 1'b1;
    #1;
    chk("req_req", mem_req, 1);
    chk("req_addr", mem_addr, addr);
    chk("req_wen", mem_wen, (strb != 0));
    chk("req_strb", mem_strb, strb);
    if (strb != 0) chk("req_wdata", mem_wdata, wdata);
    tick();
    mem_gnt = 1'b0;
    if (drop_cen) bram_cen = 1'b0;
    for (int i = 0; i < rdly; i++) begin
      #1;
      chk("rsp_wait_req", mem_req, 0);
      chk("rsp_wait_ack", mem_ack, 0);
      chk("rsp_wait_stall", bram_stall, 1);
      tick();
    end
    mem_recv = 1'b1; mem_rdata = rdata; mem_error = err;
    #1;
    chk("rsp_ack", mem_ack, 1);
    chk("rsp_req", mem_req, 0);
    chk("rsp_stall", bram_stall, 1);
    tick();
    mem_recv = 1'b0; mem_rdata = '0; mem_error = 1'b0;
    exp_err = err;
    if (strb == 0) exp_rdata = rdata;
    #1;
    chk("done_stall", bram_stall, 0);
    chk("done_req", mem_req, 0);
    chk("done_ack", mem_ack, 0);
    tick();
    if (drop_cen) begin
      // No request pending: FSM must sit in IDLE without re-issuing.
      for (int i = 0; i < 2; i++) begin
        #1;
        chk("drop_idle_stall", bram_stall, 0);
        chk("drop_idle_req", mem_req, 0);
        tick();
      end
    end else if (!b2b) begin
      bram_cen = 1'b0;
    end
  endtask

  initial begin
    logic [AW-1:0]   a;
    logic [DW-1:0]   d;
    logic [DW/8-1:0] s;
    for (int i = 0; i < 256; i++) mem_model[i] = $urandom;

    // Reset state
    #3;
    chk("rst_req", mem_req, 0);
    chk("rst_ack", mem_ack, 0);
    chk("rst_stall", bram_stall, 0);
    chk("rst_rdata", bram_rdata, 0);
    chk("rst_error", bram_error, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_strb", mem_strb, 0);
    #10 g_resetn = 1'b1;
    tick();

    // Zero-wait read
    txn(32'h0000_1000, 32'h0, 4'h0, 0, 0, 32'hDEAD_BEEF, 1'b0, 0, 0, 0);
    // Write, gnt held off 4 cycles, stray recv during REQ
    txn(32'h0000_0020, 32'h1234_5678, 4'b0011, 4, 1, 32'hFFFF_0000, 1'b0, 0, 1, 0);
    // Error response then clean read clears it
    txn(32'h0000_0040, 32'h0, 4'h0, 1, 2, 32'h0BAD_0BAD, 1'b1, 0, 0, 0);
    txn(32'h0000_0044, 32'h0, 4'h0, 0, 0, 32'h600D_600D, 1'b0, 0, 0, 0);
    // Back-to-back reads at 0x0 and 0x4
    txn(32'h0000_0000, 32'h0, 4'h0, 0, 0, mem_model[0], 1'b0, 0, 0, 1);
    txn(32'h0000_0004, 32'h0, 4'h0, 0, 0, mem_model[1], 1'b0, 0, 0, 0);
    chk("b2b_second_data", bram_rdata, mem_model[1]);
    // cen dropped in RSP: ack still given, result stored, no acceptance
    txn(32'h0000_0080, 32'h0, 4'h0, 0, 1, 32'hCAFE_F00D, 1'b1, 1, 0, 0);

    // Randomized traffic with a word-addressed memory behind the bus
    for (int n = 0; n < 40; n++) begin
      a = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
      d = $urandom;
      s = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      if (s != 0) begin
        for (int b = 0; b < 4; b++)
          if (s[b]) mem_model[a[9:2]][b*8 +: 8] = d[b*8 +: 8];
      end
      txn(a, d, s, $urandom_range(0, 3), $urandom_range(0, 3),
          (s == 0) ? mem_model[a[9:2]] : 32'($urandom),
          ($urandom_range(0, 7) == 0), ($urandom_range(0, 9) == 0),
          ($urandom_range(0, 1) == 1), ($urandom_range(0, 2) == 0));
    end
    bram_cen = 1'b0;
    tick();

    // Async reset while waiting for the response
    bram_cen = 1'b1; bram_addr = 32'h0000_0100; bram_wstrb = 4'h0;
    tick();
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    #1;
    chk("pre_rst_ack_idle", mem_ack, 0);
    mem_recv = 1'b1; mem_rdata = 32'h5555_AAAA;
    #1 g_resetn = 1'b0;
    #1;
    exp_rdata = '0; exp_err = 1'b0;
    chk("arst_req", mem_req, 0);
    chk("arst_ack", mem_ack, 0);
    chk("arst_stall_cen1", bram_stall, 1);
    chk("arst_rdata", bram_rdata, exp_rdata);
    chk("arst_error", bram_error, exp_err);
    chk("arst_addr", mem_addr, 0);
    bram_cen = 1'b0;
    #1;
    chk("arst_stall_cen0", bram_stall, 0);
    mem_recv = 1'b0; mem_rdata = '0;
    @(negedge g_clk);
    g_resetn = 1'b1;
    tick();
    txn(32'h0000_0200, 32'h0, 4'h0, 2, 0, 32'h1357_9BDF, 1'b0, 0, 0, 0);
    chk("post_rst_rdata", bram_rdata, 32'h1357_9BDF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
